mem_bus_fabric: RTL
===================

MEM_BUS_FABRIC -- requirements
Module: mem_bus_fabric

Interface
REQ-001 SHALL have parameter NR_SLAVES, default 3, number of slave ports (1..8).
REQ-002 SHALL have parameter SLV_BASE, default {32'hf000_1000, 32'hf000_0000, 32'h0000_0000}, packed NR_SLAVES*32 base addresses, slave 0 in LSBs.
REQ-003 SHALL have parameter SLV_MASK, default {32'hffff_f000, 32'hffff_f000, 32'hffff_e000}, packed NR_SLAVES*32 decode masks.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, routing FIFO depth (power of 2, 2..16).
REQ-005 SHALL have parameter VOID_RDATA, default 32'h0000_0000, read data returned for unmapped reads.
REQ-006 SHALL have ports: clk  in  1  sole clock; reset  in  1  asynchronous active-high reset.
REQ-007 SHALL have master ports: mem_cmd_valid in 1; mem_cmd_ready out 1; mem_cmd_wr in 1; mem_cmd_addr in 32; mem_cmd_wdata in 32; mem_cmd_be in 4; mem_rsp_ready out 1 read-data valid; mem_rsp_rdata out 32; mem_rsp_err out 1 unmapped-read flag.
REQ-008 SHALL have slave ports: s_cmd_valid out NR_SLAVES; s_cmd_ready in NR_SLAVES; s_cmd_wr out 1; s_cmd_addr out 32; s_cmd_wdata out 32; s_cmd_be out 4; s_rsp_ready in NR_SLAVES; s_rsp_rdata in NR_SLAVES*32.
REQ-009 SHALL have status port err_count out 16, count of unmapped accesses.

Function
REQ-010 Slave i SHALL be selected when (mem_cmd_addr & SLV_MASK[i]) == SLV_BASE[i]; lowest index wins on overlap; no match = VOID target (id NR_SLAVES).
REQ-011 s_cmd_wr/addr/wdata/be SHALL be combinational copies of master fields; zero added command latency.
REQ-012 Command stall SHALL be asserted when routing FIFO full, or when a read targets an id different from the last pushed id while FIFO non-empty (prevents response reordering).
REQ-013 s_cmd_valid[i] SHALL = mem_cmd_valid & sel[i] & !stall; mem_cmd_ready SHALL = !stall & (s_cmd_ready[sel] for mapped targets, 1 for VOID).
REQ-014 Writes SHALL never stall on FIFO state and SHALL push nothing; no write response exists.
REQ-015 Accepted read (valid & ready & !wr) SHALL push target id into routing FIFO at that clock edge.
REQ-016 Head id h < NR_SLAVES: mem_rsp_ready = s_rsp_ready[h], mem_rsp_rdata = s_rsp_rdata[h], mem_rsp_err = 0; pop when s_rsp_ready[h]=1.
REQ-017 Head id VOID: mem_rsp_ready = 1, mem_rsp_rdata = VOID_RDATA, mem_rsp_err = 1 for exactly one cycle, then pop; void read data thus appears the cycle after acceptance when FIFO otherwise empty.
REQ-018 FIFO empty: mem_rsp_ready = 0, mem_rsp_err = 0, mem_rsp_rdata = 0.
REQ-019 s_rsp_ready from a non-head slave SHALL be ignored (no pop, no output).
REQ-020 Push and pop in same cycle SHALL be allowed when not full; full blocks push even if a pop occurs that cycle (no bypass); pointers wrap modulo MAX_OUTSTANDING.
REQ-021 Each accepted VOID access (read or write) SHALL increment err_count by 1, saturating at 16'hffff.
REQ-022 Responses SHALL be delivered to master strictly in read-acceptance order.

Reset
REQ-023 reset high SHALL asynchronously empty the FIFO, clear err_count to 0, force mem_rsp_ready=0, mem_rsp_err=0; outstanding reads lost, late slave responses after reset ignored.
REQ-024 While reset high, s_cmd_valid SHALL be all-zero and mem_cmd_ready=0.

Verification
REQ-025 Read 0x0000_0100, slave 0 s_rsp_ready two cycles later with 0xdead_beef -> mem_rsp_ready=1, rdata 0xdead_beef, err=0, FIFO empty after.
REQ-026 Read 0x8000_0000 (unmapped) -> mem_cmd_ready=1 same cycle; next cycle mem_rsp_ready=1, rdata 0, err=1; err_count=1.
REQ-027 Back-to-back 5 reads to 0x0000_0000.. with slave 0 response withheld -> 4 accepted, 5th sees mem_cmd_ready=0 until first response pops.
REQ-028 Read slave 0 outstanding, then read 0xf000_0000 (slave 1) -> held (mem_cmd_ready=0, s_cmd_valid[1]=0) until slave 0 responds; write to 0xf000_0000 meanwhile accepted immediately.
REQ-029 Assert reset with 3 reads outstanding -> mem_rsp_ready=0 immediately, err_count=0; post-reset slave s_rsp_ready pulses produce no master response.
REQ-030 70000 unmapped writes -> err_count stops at 16'hffff.

Source files
------------

// File: rtl/mem_bus_fabric_if.sv
// rtl/mem_bus_fabric_if.sv - bundle of master-side and slave-side signals around mem_bus_fabric
//
// Master side : mem_cmd_valid/ready/wr/addr/wdata/be command channel,
//               mem_rsp_ready/rdata/err read-response channel.
// Slave side  : s_cmd_valid/ready per slave, shared s_cmd_wr/addr/wdata/be,
//               s_rsp_ready per slave, s_rsp_rdata packed with slave 0 in the LSBs.
// Modports    : slave  - the fabric's view (it serves the upstream master)
//               master - the surrounding environment's view (upstream master plus slaves)
interface mem_bus_fabric_if #(
    parameter int NR_SLAVES = 3
);
    logic                      mem_cmd_valid;
    logic                      mem_cmd_ready;
    logic                      mem_cmd_wr;
    logic [31:0]               mem_cmd_addr;
    logic [31:0]               mem_cmd_wdata;
    logic [3:0]                mem_cmd_be;
    logic                      mem_rsp_ready;
    logic [31:0]               mem_rsp_rdata;
    logic                      mem_rsp_err;

    logic [NR_SLAVES-1:0]      s_cmd_valid;
    logic [NR_SLAVES-1:0]      s_cmd_ready;
    logic                      s_cmd_wr;
    logic [31:0]               s_cmd_addr;
    logic [31:0]               s_cmd_wdata;
    logic [3:0]                s_cmd_be;
    logic [NR_SLAVES-1:0]      s_rsp_ready;
    logic [NR_SLAVES*32-1:0]   s_rsp_rdata;

    modport slave (
        input  mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_be,
        output mem_cmd_ready, mem_rsp_ready, mem_rsp_rdata, mem_rsp_err,
        output s_cmd_valid, s_cmd_wr, s_cmd_addr, s_cmd_wdata, s_cmd_be,
        input  s_cmd_ready, s_rsp_ready, s_rsp_rdata
    );

    modport master (
        output mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_be,
        input  mem_cmd_ready, mem_rsp_ready, mem_rsp_rdata, mem_rsp_err,
        input  s_cmd_valid, s_cmd_wr, s_cmd_addr, s_cmd_wdata, s_cmd_be,
        output s_cmd_ready, s_rsp_ready, s_rsp_rdata
    );
endinterface

// File: rtl/mem_bus_fabric.sv
// rtl/mem_bus_fabric.sv - one-master to NR_SLAVES address-decoding memory fabric with in-order read return
//
// Ports:
//   clk        in   sole clock
//   reset      in   asynchronous active-high reset
//   bus        mem_bus_fabric_if.slave: master command/response channel and slave channels
//   err_count  out  16-bit saturating count of accepted accesses to unmapped addresses
//
// Reads are tracked in a small routing FIFO holding the target id of every accepted read;
// the head id steers the response mux. Unmapped accesses go to a VOID target (id NR_SLAVES)
// that answers reads itself one cycle later with an error flag.
module mem_bus_fabric #(
    parameter int                    NR_SLAVES       = 3,
    parameter logic [NR_SLAVES*32-1:0] SLV_BASE      = {32'hf000_1000, 32'hf000_0000, 32'h0000_0000},
    parameter logic [NR_SLAVES*32-1:0] SLV_MASK      = {32'hffff_f000, 32'hffff_f000, 32'hffff_e000},
    parameter int                    MAX_OUTSTANDING = 4,
    parameter logic [31:0]           VOID_RDATA      = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_fabric_if.slave      bus,
    output logic [15:0]          err_count
);

    localparam int ID_W  = $clog2(NR_SLAVES + 1);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ID_W-1:0]  VOID_ID = ID_W'(NR_SLAVES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

    // routing FIFO state
    logic [ID_W-1:0]  fifo_id [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ID_W-1:0]  last_id;

    logic [ID_W-1:0]      sel_id;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 stall;
    logic                 target_ready;
    logic [NR_SLAVES-1:0] cmd_valid_vec;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [ID_W-1:0]      head_id;
    logic                 head_void;
    logic                 head_ready;
    logic [31:0]          head_rdata;

    // Address decode: scan from the top down so the lowest matching index is the last
    // assignment and therefore wins on overlapping windows.
    always_comb begin
        sel_id = VOID_ID;
        for (int i = NR_SLAVES - 1; i >= 0; i--) begin
            if ((bus.mem_cmd_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);

    // Only reads are held back. Because a read to a new target waits until the FIFO drains,
    // every queued entry always names the same target and responses cannot overtake.
    assign stall = !bus.mem_cmd_wr && (fifo_full || (!fifo_empty && (sel_id != last_id)));

    always_comb begin
        target_ready  = 1'b1;
        cmd_valid_vec = '0;
        for (int i = 0; i < NR_SLAVES; i++) begin
            if (sel_id == ID_W'(i)) begin
                target_ready     = bus.s_cmd_ready[i];
                cmd_valid_vec[i] = bus.mem_cmd_valid && !stall && !reset;
            end
        end
    end

    assign bus.s_cmd_valid   = cmd_valid_vec;
    assign bus.s_cmd_wr      = bus.mem_cmd_wr;
    assign bus.s_cmd_addr    = bus.mem_cmd_addr;
    assign bus.s_cmd_wdata   = bus.mem_cmd_wdata;
    assign bus.s_cmd_be      = bus.mem_cmd_be;
    assign bus.mem_cmd_ready = !reset && !stall && target_ready;

    assign accept = bus.mem_cmd_valid && bus.mem_cmd_ready;
    assign push   = accept && !bus.mem_cmd_wr;

    // Response steering from the FIFO head; responses from any other slave are ignored.
    assign head_id   = fifo_id[rd_ptr];
    assign head_void = (head_id == VOID_ID);

    always_comb begin
        head_ready = 1'b0;
        head_rdata = '0;
        for (int i = 0; i < NR_SLAVES; i++) begin
            if (head_id == ID_W'(i)) begin
                head_ready = bus.s_rsp_ready[i];
                head_rdata = bus.s_rsp_rdata[i*32 +: 32];
            end
        end
    end

    // A VOID head answers unconditionally, so it is presented for exactly one cycle.
    assign pop = !fifo_empty && (head_void || head_ready);

    assign bus.mem_rsp_ready = !reset && pop;
    assign bus.mem_rsp_err   = !reset && !fifo_empty && head_void;
    assign bus.mem_rsp_rdata = (reset || fifo_empty) ? 32'h0 :
                               head_void             ? VOID_RDATA : head_rdata;

    // FIFO storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr] <= sel_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last_id <= VOID_ID;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                last_id <= sel_id;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (accept && (sel_id == VOID_ID) && (err_count != 16'hffff)) begin
            err_count <= err_count + 16'd1;
        end
    end

endmodule
